// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [2:0] {
    IDLE, LOAD, ST_FULL, RMW_RD, RMW_WR, RESP
  } lsu_state_t;

  // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extract + sign/zero extend, and store byte merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int NUM_LANES = 8,
  localparam int OFF_W = $clog2(NUM_LANES),
  localparam int W = NUM_LANES * 8
) (
  input  logic [NUM_LANES-1:0][7:0] word,
  input  logic [2:0]                funct3,
  input  logic [OFF_W-1:0]          off,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [W-1:0]              load_data,
  output logic [NUM_LANES-1:0][7:0] merged
);

  logic [W-1:0]                shifted;
  logic [NUM_LANES-1:0][7:0]   wshift;
  logic [NUM_LANES-1:0]        size_mask;
  logic [NUM_LANES-1:0]        mask;

  // Shift the addressed lanes down to bit 0 and extend to full width.
  always_comb begin
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_B:    load_data = {{(W-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(W-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(W-32){shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {{(W-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(W-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_data = {{(W-32){1'b0}}, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  // Lane-enable mask for the store: size lanes starting at the byte offset.
  always_comb begin
    case (funct3[1:0])
      2'd0:    size_mask = NUM_LANES'(1);
      2'd1:    size_mask = NUM_LANES'(3);
      2'd2:    size_mask = NUM_LANES'(15);
      default: size_mask = '1;
    endcase
    mask   = size_mask << off;
    wshift = wdata << {off, 3'b000};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = mask[i] ? wshift[i] : word[i];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller: one request at a time, drives the 64-bit byte-addressed memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_re,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int NUM_LANES = XLEN / 8;
  localparam int OFF_W     = $clog2(NUM_LANES);

  lsu_state_t       state;
  logic [2:0]       cap_funct3;
  logic [OFF_W-1:0] cap_off;
  logic [XLEN-1:0]  cap_wdata;

  logic [3:0]       size;
  logic             misal, oor, illegal, err;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  load_data, merged;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Decode the incoming request: size, alignment, range and legality.
  always_comb begin
    size    = size_of(req_funct3);
    misal   = |(req_addr[OFF_W-1:0] & (size[OFF_W-1:0] - OFF_W'(1)));
    oor     = ({1'b0, req_addr} + (XLEN+1)'(size)) > (XLEN+1)'(MEM_BYTES);
    illegal = (req_funct3 == F3_ILL) || (req_we && req_funct3[2]);
    err     = misal || oor || illegal;
    base    = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  end

  lsu_align #(.NUM_LANES(NUM_LANES)) u_align (
    .word      (mem_rdata),
    .funct3    (cap_funct3),
    .off       (cap_off),
    .wdata     (cap_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Request FSM with registered memory and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_funct3 <= '0;
      cap_off    <= '0;
      cap_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_funct3 <= req_funct3;
          cap_off    <= req_addr[OFF_W-1:0];
          cap_wdata  <= req_wdata;
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else if (!req_we) begin
            state    <= LOAD;
            mem_re   <= 1'b1;
            mem_addr <= base;
          end else if (req_funct3 == F3_D) begin
            state     <= ST_FULL;
            mem_we    <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end else begin
            state    <= RMW_RD;
            mem_re   <= 1'b1;
            mem_addr <= base;
          end
        end
        LOAD: begin
          mem_re     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
          state      <= RESP;
        end
        ST_FULL: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // The read word is merged as it is captured, so the write data is
        // ready on mem_wdata for the whole RMW_WR cycle.
        RMW_RD: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, vector table, response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, busy, mem_re, mem_we;
  logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_BYTES(256), .XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory model
  logic [7:0] mem [0:255];
  logic       mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'd3; mem[8] <= 8'd1; mem[16] <= 8'd4; mem[24] <= 8'd2;
      mem_loaded <= 1'b1;
    end else if (mem_we && mem_addr <= 64'd248) begin
      for (int i = 0; i < 8; i++) mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[i*8 +: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'd248)
      for (int i = 0; i < 8; i++) mem_rdata[i*8 +: 8] = mem[mem_addr[7:0] + 8'(i)];
  end

  int checks = 0, errors = 0;
  int cyc = 0, re_cnt = 0, we_cnt = 0, resp_cnt = 0, push_cnt = 0, last_acc = 0;

  typedef struct {
    string       name;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd, input logic e, input int lat);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.err = e; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Activity counters, exclusivity check and response scoreboard
  always @(negedge clk) begin
    if (mem_re) re_cnt++;
    if (mem_we) we_cnt++;
    chk("re_we_exclusive", {63'b0, mem_re & mem_we}, 64'd0);
    if (resp_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_t e;
        e = q.pop_front();
        resp_cnt++;
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {63'b0, resp_err}, {63'b0, e.err});
        chk({e.name, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic issue(input vec_t v, input bit hold);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      chk({v.name, "_busy_wait"}, {63'b0, busy}, 64'd1);
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout: got req_ready=0 expected 1", v.name);
      return;
    end
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    e.name = v.name; e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.acc = cyc;
    q.push_back(e);
    push_cnt++;
    last_acc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !req_ready) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got pending=%0d expected 0", nm, q.size());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, {63'b0, req_ready}, 64'd1);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_resp_valid"}, {63'b0, resp_valid}, 64'd0);
    chk({tag, "_resp_err"}, {63'b0, resp_err}, 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_mem_re"}, {63'b0, mem_re}, 64'd0);
    chk({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int re0, we0, a0, r0, ere, ewe;
    vec_t v;

    vt.push_back(mk("ld16",   0, F3_D,  16,  0, 64'h4, 0, 2));
    vt.push_back(mk("sb9",    1, F3_B,  9,   64'hFF, 0, 0, 3));
    vt.push_back(mk("lb9",    0, F3_B,  9,   0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2));
    vt.push_back(mk("lbu9",   0, F3_BU, 9,   0, 64'hFF, 0, 2));
    vt.push_back(mk("ld8",    0, F3_D,  8,   0, 64'hFF01, 0, 2));
    vt.push_back(mk("sd24",   1, F3_D,  24,  64'h1122_3344_5566_7788, 0, 0, 2));
    vt.push_back(mk("lw28",   0, F3_W,  28,  0, 64'h1122_3344, 0, 2));
    vt.push_back(mk("lh24",   0, F3_H,  24,  0, 64'h7788, 0, 2));
    vt.push_back(mk("lb24",   0, F3_B,  24,  0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2));
    vt.push_back(mk("lhu30",  0, F3_HU, 30,  0, 64'h1122, 0, 2));
    vt.push_back(mk("sw36",   1, F3_W,  36,  64'hDEAD_BEEF, 0, 0, 3));
    vt.push_back(mk("sh34",   1, F3_H,  34,  64'hFFFF_FFFF_FFFF_ABCD, 0, 0, 3));
    vt.push_back(mk("ld32",   0, F3_D,  32,  0, 64'hDEAD_BEEF_ABCD_0000, 0, 2));
    vt.push_back(mk("lw36",   0, F3_W,  36,  0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 2));
    vt.push_back(mk("lwu36",  0, F3_WU, 36,  0, 64'h0000_0000_DEAD_BEEF, 0, 2));
    vt.push_back(mk("lh34",   0, F3_H,  34,  0, 64'hFFFF_FFFF_FFFF_ABCD, 0, 2));
    vt.push_back(mk("lw2",    0, F3_W,  2,   0, 0, 1, 1));
    vt.push_back(mk("ld256",  0, F3_D,  256, 0, 0, 1, 1));
    vt.push_back(mk("lh255",  0, F3_H,  255, 0, 0, 1, 1));
    vt.push_back(mk("lb256",  0, F3_B,  256, 0, 0, 1, 1));
    vt.push_back(mk("sbu40",  1, F3_BU, 40,  64'h12, 0, 1, 1));
    vt.push_back(mk("ill0",   0, F3_ILL, 0,  0, 0, 1, 1));
    vt.push_back(mk("sd248",  1, F3_D,  248, 64'hA5A5_0000_0000_5A5A, 0, 0, 2));
    vt.push_back(mk("ld248",  0, F3_D,  248, 0, 64'hA5A5_0000_0000_5A5A, 0, 2));
    vt.push_back(mk("lb255",  0, F3_B,  255, 0, 64'hFFFF_FFFF_FFFF_FFA5, 0, 2));
    vt.push_back(mk("sd252e", 1, F3_D,  252, 64'h1, 0, 1, 1));

    #12;
    chk_reset("rst");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single requests with memory activity per request
    foreach (vt[i]) begin
      v = vt[i];
      re0 = re_cnt; we0 = we_cnt;
      issue(v, 1'b0);
      wait_done(v.name);
      ere = (v.err || (v.we && v.f3 == F3_D)) ? 0 : 1;
      ewe = (v.err || !v.we) ? 0 : 1;
      chk({v.name, "_re_cycles"}, 64'(re_cnt - re0), 64'(ere));
      chk({v.name, "_we_cycles"}, 64'(we_cnt - we0), 64'(ewe));
    end

    // Back-to-back requests with req_valid held high
    r0 = resp_cnt;
    issue(mk("b2b_ld16", 0, F3_D, 16, 0, 64'h4, 0, 2), 1'b1);
    a0 = last_acc;
    issue(mk("b2b_ld8", 0, F3_D, 8, 0, 64'hFF01, 0, 2), 1'b0);
    chk("b2b_accept_spacing", 64'(last_acc - a0), 64'd3);
    wait_done("b2b");
    chk("b2b_resp_count", 64'(resp_cnt - r0), 64'd2);

    // Reset during RMW_RD of a halfword store at 0
    we0 = we_cnt;
    issue(mk("sh0_abort", 1, F3_H, 0, 64'h5555, 0, 0, 3), 1'b0);
    chk("sh0_in_rmw_rd_re", {63'b0, mem_re}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("midrst");
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    chk("sh0_abort_no_write", 64'(we_cnt - we0), 64'd0);
    issue(mk("ld0_after_rst", 0, F3_D, 0, 0, 64'h3, 0, 2), 1'b0);
    wait_done("ld0_after_rst");

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side controller between the pipeline MEM stage and the byte-addressed 64-bit Data_Memory. It accepts one load/store request at a time with a valid/ready handshake. It drives the memory's address, data, read-enable and write-enable. It performs byte-lane extraction with sign/zero extension for LB/LH/LW/LD/LBU/LHU/LWU, and read-modify-write for SB/SH/SW. It asserts busy so hazard logic can stall the pipeline.

Parameters:
MEM_BYTES, 256, size of the backing memory in bytes; any access with addr+size > MEM_BYTES is an error.
XLEN, 64, data and address width.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data (low bytes used for sub-word)
resp_valid  output  1  one-cycle pulse, response ready
resp_rdata  output  XLEN  extended load result (0 for stores and errors)
resp_err  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
busy  output  1  high in any state except IDLE
mem_addr  output  XLEN  to Mem_Addr
mem_wdata  output  XLEN  to Write_Data
mem_re  output  1  to MemRead
mem_we  output  1  to MemWrite
mem_rdata  input  XLEN  from Read_Data (combinational, 8 bytes little-endian from mem_addr)

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_re=0, mem_we=0; mem_addr=0, mem_wdata=0; busy=0; captured request registers cleared.
- Handshake: the request is accepted on a rising edge with req_valid and req_ready both high. All req_* fields are captured at acceptance and are don't-care afterwards. No new acceptance until the state returns to IDLE.
- Size from funct3[1:0]: 1, 2, 4 or 8 bytes. Misaligned means addr mod size != 0. Store with funct3[2]=1, or funct3=111, is illegal.
- States: IDLE, LOAD, ST_FULL, RMW_RD, RMW_WR, RESP.
- IDLE -> on accept:
  - error -> RESP with err=1 and no memory access;
  - load -> LOAD;
  - SD -> ST_FULL;
  - SB/SH/SW -> RMW_RD.
- LOAD (1 cycle):
  - mem_re=1, mem_addr = addr with bits[2:0] cleared.
  - At cycle end, capture mem_rdata, extract lanes at offset addr[2:0], sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1).
  - -> RESP.
- ST_FULL (1 cycle): mem_we=1, mem_addr=addr, mem_wdata=wdata. -> RESP.
- RMW_RD (1 cycle): mem_re=1, mem_addr=aligned base; capture the 8-byte word. -> RMW_WR.
- RMW_WR (1 cycle):
  - mem_we=1, mem_addr=aligned base.
  - mem_wdata = captured word with lanes [offset, offset+size) replaced by wdata low bytes.
  - -> RESP.
- RESP (1 cycle): resp_valid=1 with rdata/err. -> IDLE; req_ready returns high the next cycle.
- Latency, accept edge to resp_valid: error 1 cycle, load 2, SD 2, sub-word store 3. Throughput: one request per latency+1 cycles.
- mem_re and mem_we are never high together. Both are 0 outside LOAD/ST_FULL/RMW_*.
- Reset asserted mid-operation aborts immediately with no further mem_we. A write is committed only if the write edge preceded reset.
- mem_addr range: aligned base + 7 < MEM_BYTES is guaranteed for every issued access.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B..F3_WU), state enum lsu_state_t, size-decode function.
- Sub-module lsu_align (combinational): extract+extend for loads, byte-merge for stores. Shared by LOAD and RMW_WR.
- The FSM and registers stay in load_store_unit.

Test Plan (memory preloaded: byte0=3, byte8=1, byte16=4, byte24=2, rest 0):
1. LD addr 16 -> resp_valid 2 cycles after accept, rdata=0x4, err=0; mem_re high exactly 1 cycle.
2. SB wdata=0xFF addr 9, then LB addr 9 -> LB rdata=0xFFFF_FFFF_FFFF_FFFF and LBU rdata=0xFF; bytes 8 and 10 unchanged (LD addr 8 -> 0x0000_0000_0000_FF01); store latency 3.
3. SD 0x1122334455667788 at 24, then LW 28 -> 0x0000_0000_1122_3344, then LH 24 -> 0x7788.
4. LW addr 2 (misaligned) and LD addr 256 (out of range) -> resp_err=1 after 1 cycle, rdata=0, mem_re/mem_we never asserted.
5. req_valid held high back-to-back -> second request accepted only after RESP; req_ready low and busy high throughout; no lost or duplicated response.
6. reset asserted during RMW_RD of SH at 0 -> all outputs return to reset values asynchronously; LD 0 afterward -> 0x3 (no partial write).
